// File: rtl/add_pkg.sv
// Shared types and constants for the byte-serial adder.
package add_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned NBYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_t;

endpackage

// File: rtl/RCA_8.sv
// 8-bit ripple-carry slice adder.
module RCA_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    // Full-adder chain from bit 0 upward.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[8];
    end

endmodule

// File: rtl/byte_serial_add32.sv
// Byte-serial adder: streams operands LSB-byte first through one 8-bit slice.
module byte_serial_add32
    import add_pkg::*;
#(
    parameter int unsigned NBYTES = NBYTES_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout,
    output logic                     overflow
);

    localparam int unsigned DATA_W = BYTE_W * NBYTES;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    ser_state_t          state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                carry_q;
    logic [DATA_W-1:0]   sum_q;
    logic                cout_q;
    logic                overflow_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [BYTE_W-1:0]   slice_a;
    logic [BYTE_W-1:0]   slice_b;
    logic [BYTE_W-1:0]   slice_sum;
    logic                slice_cout;
    logic                last_byte;

    // Byte mux selecting the current operand slice.
    always_comb begin
        slice_a   = a_q[BYTE_W*idx_q +: BYTE_W];
        slice_b   = b_q[BYTE_W*idx_q +: BYTE_W];
        last_byte = (idx_q == IDX_W'(NBYTES - 1));
    end

    RCA_8 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Control FSM with operand, carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[BYTE_W*idx_q +: BYTE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (last_byte) begin
                        cout_q      <= slice_cout;
                        overflow_q  <= (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                                       (slice_sum[BYTE_W-1] != a_q[DATA_W-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_byte_serial_add32.sv
// Self-checking bench for byte_serial_add32 against an arithmetic reference.
module tb_byte_serial_add32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    byte_serial_add32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic c);
        logic [32:0] u;
        longint      s;
        logic        ov;
        u  = 33'(x) + 33'(y) + 33'(c);
        s  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {ov, u};
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                          input int hold);
        logic [33:0] e;
        int          lat;
        e = ref_add(ta, tb_v, tc);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        chk("pre_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b1;
        lat = 1;
        chk("run_in_ready", 64'(in_ready), 64'd0);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'd5);
        chk("sum", 64'(sum), 64'(e[31:0]));
        chk("cout", 64'(cout), 64'(e[32]));
        chk("overflow", 64'(overflow), 64'(e[33]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_sum", 64'(sum), 64'(e[31:0]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("kept_sum", 64'(sum), 64'(e[31:0]));
    endtask

    initial begin
        logic [33:0] q[$];
        logic [33:0] e;
        int          done_n;
        int          cyc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // Directed corner cases.
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0);
        run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 3);

        // Reset in the middle of RUN.
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        chk("postrst_out_valid", 64'(out_valid), 64'd0);
        chk("postrst_sum", 64'(sum), 64'd0);
        run_op(32'd5, 32'd3, 1'b0, 0);

        // Back-to-back random traffic with random back-pressure.
        done_n = 0;
        cyc    = 0;
        @(negedge clk);
        while (done_n < 1000 && cyc < 40000) begin
            a         = $urandom;
            b         = $urandom;
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = 1'b1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rand_sum", 64'(sum), 64'(e[31:0]));
                    chk("rand_cout", 64'(cout), 64'(e[32]));
                    chk("rand_overflow", 64'(overflow), 64'(e[33]));
                end
                done_n++;
            end
            if (in_valid && in_ready) q.push_back(ref_add(a, b, cin));
            @(negedge clk);
            cyc++;
        end
        chk("rand_completed", 64'(done_n), 64'd1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
